// File: rtl/ram_loader.sv
// ram_loader: clears a single-port RAM to fill_value, then loads a little-endian byte stream into it.
// Optional feature: define RAM_LOADER_VERIFY_EN to add a checksum read-back pass (VERIFY state).
module ram_loader #(
    parameter int                    address_width = 8,
    parameter int                    data_width    = 16,
    parameter logic [data_width-1:0] fill_value    = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [7:0]               s_data,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    output logic [address_width-1:0] ram_address,
    output logic [data_width-1:0]    ram_data,
    output logic                     ram_wren,
    input  logic [data_width-1:0]    ram_q,
    output logic                     busy,
    output logic                     done,
    output logic [address_width:0]   word_count,
    output logic                     overflow,
    output logic                     error
);
    localparam int BPW = data_width / 8;
    localparam int LW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [address_width:0] DEPTH = {1'b1, {address_width{1'b0}}};
    localparam logic [address_width:0] LAST_ADDR = {1'b0, {address_width{1'b1}}};
    localparam logic [address_width:0] ONE = {{address_width{1'b0}}, 1'b1};
    localparam logic [LW-1:0] LAST_LANE = LW'(BPW - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
`ifdef RAM_LOADER_VERIFY_EN
        VERIFY,
`endif
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [address_width:0]   cnt_q, cnt_d;
    logic [address_width:0]   word_count_q, word_count_d;
    logic                     overflow_q, overflow_d;
    logic                     error_q, error_d;
    logic [LW-1:0]            lane_q, lane_d;
    logic [data_width-1:0]    acc_q, acc_d;
    logic                     wr_pend_q, wr_pend_d;
    logic [data_width-1:0]    wr_data_q, wr_data_d;
    logic                     fin_q, fin_d;
    logic [data_width-1:0]    word;
    logic                     full;
    logic                     accept;
`ifdef RAM_LOADER_VERIFY_EN
    logic [data_width-1:0]    sum_q, sum_d;
    logic [data_width-1:0]    vsum_q, vsum_d;
`else
    logic                     unused_ram_q;
    assign unused_ram_q = ^ram_q;
`endif

    // Byte lane merge, capacity check (counting an in-flight write) and handshake.
    assign word = acc_q | (data_width'(s_data) << {lane_q, 3'b000});
    assign full = (word_count_q + {{address_width{1'b0}}, wr_pend_q}) == DEPTH;
    assign s_ready = (state_q == LOAD) && !fin_q;
    assign accept = s_ready && s_valid;
    assign word_count = word_count_q;
    assign overflow = overflow_q;
    assign error = error_q;

    // Next-state logic and RAM-side outputs for each phase of the sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
        error_d      = error_q;
        lane_d       = lane_q;
        acc_d        = acc_q;
        wr_pend_d    = 1'b0;
        wr_data_d    = wr_data_q;
        fin_d        = fin_q;
`ifdef RAM_LOADER_VERIFY_EN
        sum_d        = sum_q;
        vsum_d       = vsum_q;
`endif
        ram_wren     = 1'b0;
        ram_address  = '0;
        ram_data     = '0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = CLEAR;
                    cnt_d        = '0;
                    word_count_d = '0;
                    overflow_d   = 1'b0;
                    error_d      = 1'b0;
                    lane_d       = '0;
                    acc_d        = '0;
                    fin_d        = 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
                    sum_d        = '0;
`endif
                end
            end
            CLEAR: begin
                busy        = 1'b1;
                ram_wren    = 1'b1;
                ram_address = cnt_q[address_width-1:0];
                ram_data    = fill_value;
                cnt_d       = cnt_q + ONE;
                if (cnt_q == LAST_ADDR) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                busy        = 1'b1;
                ram_wren    = wr_pend_q;
                ram_address = word_count_q[address_width-1:0];
                ram_data    = wr_data_q;
                if (wr_pend_q) begin
                    word_count_d = word_count_q + ONE;
`ifdef RAM_LOADER_VERIFY_EN
                    sum_d        = sum_q + wr_data_q;
`endif
                end
                if (accept) begin
                    if (full) begin
                        overflow_d = 1'b1;
                    end else if (lane_q == LAST_LANE || s_last) begin
                        wr_pend_d = 1'b1;
                        wr_data_d = word;
                        acc_d     = '0;
                        lane_d    = '0;
                    end else begin
                        acc_d  = word;
                        lane_d = lane_q + LW'(1);
                    end
                    fin_d = s_last;
                end
                // fin_q marks the cycle carrying the final write; leave after it.
                if (fin_q) begin
`ifdef RAM_LOADER_VERIFY_EN
                    state_d = (word_count_d == '0) ? DONE : VERIFY;
                    cnt_d   = '0;
                    vsum_d  = '0;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef RAM_LOADER_VERIFY_EN
            VERIFY: begin
                busy        = 1'b1;
                ram_address = cnt_q[address_width-1:0];
                cnt_d       = cnt_q + ONE;
                if (cnt_q != '0) vsum_d = vsum_q + ram_q;
                if (cnt_q == word_count_q) begin
                    state_d = DONE;
                    error_d = (vsum_q + ram_q) != sum_q;
                end
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            error_q      <= 1'b0;
            lane_q       <= '0;
            acc_q        <= '0;
            wr_pend_q    <= 1'b0;
            wr_data_q    <= '0;
            fin_q        <= 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
            sum_q        <= '0;
            vsum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            error_q      <= error_d;
            lane_q       <= lane_d;
            acc_q        <= acc_d;
            wr_pend_q    <= wr_pend_d;
            wr_data_q    <= wr_data_d;
            fin_q        <= fin_d;
`ifdef RAM_LOADER_VERIFY_EN
            sum_q        <= sum_d;
            vsum_q       <= vsum_d;
`endif
        end
    end
endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL provide parameter address_width, default 8, RAM word-address width.
REQ-002 SHALL provide parameter data_width, default 16, RAM word width; multiple of 8; bytes per word BPW = data_width/8.
REQ-003 SHALL provide parameter fill_value, default 0, data_width-bit word written to every address during clear.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin a clear+load sequence, sampled in IDLE only.
REQ-007 s_data  input  8  download byte.
REQ-008 s_valid  input  1  s_data valid.
REQ-009 s_last  input  1  qualifies the final byte of the stream, valid with s_valid.
REQ-010 s_ready  output  1  byte accepted when s_valid && s_ready at a rising clk edge.
REQ-011 ram_address  output  address_width  to single-port RAM address.
REQ-012 ram_data  output  data_width  to RAM write data.
REQ-013 ram_wren  output  1  to RAM write enable.
REQ-014 ram_q  input  data_width  RAM read data, valid one cycle after the address is presented.
REQ-015 busy  output  1  high in CLEAR, LOAD and VERIFY.
REQ-016 done  output  1  one-cycle pulse at sequence end.
REQ-017 word_count  output  address_width+1  words written by LOAD, held until the next start.
REQ-018 overflow  output  1  sticky; set if bytes arrive beyond RAM capacity.
REQ-019 error  output  1  sticky; set on verify checksum mismatch.

Function
REQ-020 States SHALL be IDLE, CLEAR, LOAD, VERIFY and DONE; start in IDLE clears word_count, overflow and error, then enters CLEAR.
REQ-021 CLEAR SHALL write fill_value to addresses 0..2^address_width-1, one per cycle, ram_wren=1, exactly 2^address_width cycles, then enter LOAD.
REQ-022 s_ready SHALL be 1 only in LOAD; bytes presented outside LOAD are not accepted.
REQ-023 LOAD SHALL pack accepted bytes little-endian: the first byte goes to bits [7:0], the BPW-th byte completes the word.
REQ-024 A completed word, or a partial word closed by s_last with unfilled lanes zero, SHALL be written on the cycle after its final byte is accepted: ram_wren=1, ram_address=word_count, then word_count increments.
REQ-025 Byte acceptance SHALL continue without stall while a word write is in flight; throughput is one byte per cycle.
REQ-026 Once word_count = 2^address_width, further bytes SHALL be accepted and discarded, overflow set, and no write issued.
REQ-027 LOAD SHALL keep a data_width-bit modulo-2^data_width sum of all written words.
REQ-028 After the s_last write, LOAD SHALL enter VERIFY if compiled in, else DONE.
REQ-029 DONE SHALL assert done for one cycle and return to IDLE; start during busy or DONE SHALL be ignored.
REQ-030 ram_wren SHALL be 0 in IDLE, VERIFY and DONE, and on LOAD cycles with no pending write.

Reset
REQ-031 reset_n low SHALL immediately force IDLE and set s_ready, ram_wren, busy, done, overflow and error to 0; ram_address, ram_data and word_count SHALL be 0.
REQ-032 Reset mid-sequence SHALL abandon the sequence; no further RAM writes.

Configuration
REQ-033 With RAM_LOADER_VERIFY_EN defined, VERIFY SHALL read addresses 0..word_count-1 one per cycle, sum ram_q one cycle later, and set error if the sum differs from the LOAD sum; duration word_count+1 cycles; word_count=0 skips to DONE.
REQ-034 Without RAM_LOADER_VERIFY_EN, VERIFY SHALL not exist, error SHALL be tied 0, and LOAD SHALL go directly to DONE.

Verification (address_width=4, data_width=16, fill_value=16'hFFFF)
REQ-035 start pulse -> busy rises; 16 consecutive writes of FFFF to addresses 0..15, then s_ready=1.
REQ-036 Bytes 11,22,33,44,55 (55 with s_last) -> writes 2211@0, 4433@1, 0055@2; word_count=3; done pulses once.
REQ-037 34 bytes streamed without gaps -> 16 writes, overflow=1, word_count=16, s_ready never drops during LOAD.
REQ-038 With verify, RAM model corrupts address 1 after its write -> error=1 at done; an uncorrupted run -> error=0.
REQ-039 reset_n low in the middle of CLEAR -> ram_wren=0 and busy=0 asynchronously; the next start restarts CLEAR at address 0.
REQ-040 start asserted during LOAD -> ignored; the sequence completes normally.
